// File: rtl/tag_array_loader.sv
// tag_array_loader
//   Warm-up loader sitting between the cache and its tag SRAM (tag_array_ext).
//   While idle (or after a finished load) the cache drives the SRAM port
//   directly. A start pulse takes over the port, writes one full row per set
//   from the in_* stream (sets 0..SETS-1), and optionally reads every set back
//   to compare an XOR checksum of written vs. read rows.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, verify_en      start pulse; verify_en captured with it
//   in_valid/ready/data   warmup row stream, one row per set
//   c_*                   cache-side SRAM request / response
//   RW0_*                 SRAM port towards tag_array_ext (read data 1 cycle late)
//   busy, done, mismatch  loader status; done/mismatch held until next start

module tag_array_loader #(
    parameter int SETS      = 64,
    parameter int WAYS      = 4,
    parameter int TAG_BITS  = 22,
    parameter int ADDR_BITS = $clog2(SETS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     verify_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WAYS*TAG_BITS-1:0] in_data,
    input  logic                     c_en,
    input  logic                     c_wmode,
    input  logic [ADDR_BITS-1:0]     c_addr,
    input  logic [WAYS*TAG_BITS-1:0] c_wdata,
    input  logic [WAYS-1:0]          c_wmask,
    output logic                     c_ready,
    output logic [WAYS*TAG_BITS-1:0] c_rdata,
    output logic                     RW0_en,
    output logic                     RW0_wmode,
    output logic [ADDR_BITS-1:0]     RW0_addr,
    output logic [WAYS*TAG_BITS-1:0] RW0_wdata,
    output logic [WAYS-1:0]          RW0_wmask,
    input  logic [WAYS*TAG_BITS-1:0] RW0_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     mismatch
);

    localparam int ROW_BITS = WAYS * TAG_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_SET = ADDR_BITS'(SETS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        DRAIN,
        CMP,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_BITS-1:0]  set_cnt;
    logic [ROW_BITS-1:0]   wr_acc;
    logic [ROW_BITS-1:0]   rd_acc;
    logic                  verify_q;
    logic                  rd_valid;   // a read was issued last cycle, RW0_rdata is live
    logic                  cache_owns;

    assign cache_owns = (state == IDLE) || (state == DONE);
    assign c_ready    = cache_owns;
    assign busy       = !cache_owns;
    assign in_ready   = (state == LOAD);
    assign c_rdata    = RW0_rdata;

    // SRAM port mux: cache pass-through when idle, loader traffic otherwise.
    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wdata = '0;
        RW0_wmask = '0;
        case (state)
            IDLE, DONE: begin
                RW0_en    = c_en;
                RW0_wmode = c_wmode;
                RW0_addr  = c_addr;
                RW0_wdata = c_wdata;
                RW0_wmask = c_wmask;
            end
            LOAD: begin
                RW0_en    = in_valid;
                RW0_wmode = 1'b1;
                RW0_addr  = set_cnt;
                RW0_wdata = in_data;
                RW0_wmask = '1;
            end
            VERIFY: begin
                RW0_en    = 1'b1;
                RW0_addr  = set_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            set_cnt  <= '0;
            wr_acc   <= '0;
            rd_acc   <= '0;
            verify_q <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            rd_valid <= (state == VERIFY);
            // Readback data lands one cycle after its address; the final
            // read is folded in during DRAIN.
            if (rd_valid)
                rd_acc <= rd_acc ^ RW0_rdata;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        verify_q <= verify_en;
                        done     <= 1'b0;
                        mismatch <= 1'b0;
                        set_cnt  <= '0;
                        wr_acc   <= '0;
                        rd_acc   <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        wr_acc <= wr_acc ^ in_data;
                        // Last set wins over the increment so the counter never wraps.
                        if (set_cnt == LAST_SET) begin
                            set_cnt <= '0;
                            if (verify_q) begin
                                state <= VERIFY;
                            end else begin
                                done     <= 1'b1;
                                mismatch <= 1'b0;
                                state    <= DONE;
                            end
                        end else begin
                            set_cnt <= set_cnt + 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    if (set_cnt == LAST_SET) begin
                        set_cnt <= '0;
                        state   <= DRAIN;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                DRAIN: state <= CMP;
                CMP: begin
                    mismatch <= (wr_acc != rd_acc);
                    done     <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_array_loader.sv
module tb_tag_array_loader;

    localparam int SETS      = 64;
    localparam int WAYS      = 4;
    localparam int TAG_BITS  = 22;
    localparam int ADDR_BITS = 6;
    localparam int ROW       = WAYS * TAG_BITS;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic                 verify_en = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [ROW-1:0]       in_data = '0;
    logic                 c_en = 1'b1;
    logic                 c_wmode = 1'b0;
    logic [ADDR_BITS-1:0] c_addr = 6'd5;
    logic [ROW-1:0]       c_wdata = '0;
    logic [WAYS-1:0]      c_wmask = '0;
    logic                 c_ready;
    logic [ROW-1:0]       c_rdata;
    logic                 RW0_en, RW0_wmode;
    logic [ADDR_BITS-1:0] RW0_addr;
    logic [ROW-1:0]       RW0_wdata;
    logic [WAYS-1:0]      RW0_wmask;
    logic [ROW-1:0]       RW0_rdata = '0;
    logic                 busy, done, mismatch;

    int checks = 0;
    int failures = 0;

    tag_array_loader #(
        .SETS(SETS), .WAYS(WAYS), .TAG_BITS(TAG_BITS), .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .verify_en(verify_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .c_en(c_en), .c_wmode(c_wmode), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_wmask(c_wmask), .c_ready(c_ready), .c_rdata(c_rdata),
        .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
        .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata),
        .busy(busy), .done(done), .mismatch(mismatch)
    );

    always #5 clock = ~clock;

    // Behavioural tag SRAM, 1-cycle read latency; optional corruption of set 17 bit 3.
    logic [ROW-1:0] mem [SETS];
    logic flip_en = 1'b0;
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int w = 0; w < WAYS; w++)
                    if (RW0_wmask[w])
                        mem[RW0_addr][w*TAG_BITS +: TAG_BITS] <= RW0_wdata[w*TAG_BITS +: TAG_BITS]
                            ^ ((flip_en && RW0_addr == 6'd17 && w == 0) ? 22'd8 : 22'd0);
            end else begin
                RW0_rdata <= mem[RW0_addr];
            end
        end
    end

    // Cycle counter and traffic monitor (sampled on the falling edge).
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int wr_cnt = 0, rd_cnt = 0, gap_bad = 0, cr_bad = 0, t_last = -1, done_rise = -1;
    int wr_log [2048];
    int rd_log [2048];
    logic done_prev = 1'b0;
    always @(negedge clock) begin
        if (RW0_en && RW0_wmode && in_ready) begin
            if (wr_cnt < 2048) wr_log[wr_cnt] = int'(RW0_addr);
            if (RW0_addr == 6'(SETS - 1)) t_last = cyc;
            wr_cnt++;
        end
        if (busy && RW0_en && !RW0_wmode) begin
            if (rd_cnt < 2048) rd_log[rd_cnt] = int'(RW0_addr);
            rd_cnt++;
        end
        if (in_ready && !in_valid && RW0_en) gap_bad++;
        if (busy && c_ready) cr_bad++;
        if (done && !done_prev) done_rise = cyc;
        done_prev = done;
    end

    function automatic logic [ROW-1:0] row_of(input int i);
        logic [ROW-1:0] r;
        for (int w = 0; w < WAYS; w++) r[w*TAG_BITS +: TAG_BITS] = TAG_BITS'(i);
        return r;
    endfunction

    task automatic do_start(input logic v);
        @(posedge clock); #1;
        start = 1'b1; verify_en = v;
        @(posedge clock); #1;
        start = 1'b0; verify_en = 1'b0;
    endtask

    task automatic feed(input int first, input int n, input bit gaps);
        int i = first;
        int guard = 0;
        logic acc;
        while (i < first + n && guard < 2000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = row_of(i);
            #2;
            acc = in_valid && in_ready;
            @(posedge clock); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (done) begin ok = 1'b1; break; end
            @(posedge clock); #1;
        end
        @(negedge clock); #1;
    endtask

    task automatic test_reset;
        c_en = 1'b1; c_addr = 6'd5; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (RW0_en !== 1'b1) begin failures++; $display("FAIL rst_rw0_en got=%0b exp=1", RW0_en); end
        checks++; if (RW0_addr !== 6'd5) begin failures++; $display("FAIL rst_rw0_addr got=%0d exp=5", RW0_addr); end
        checks++; if (c_ready !== 1'b1) begin failures++; $display("FAIL rst_c_ready got=%0b exp=1", c_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL rst_mismatch got=%0b exp=0", mismatch); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
        reset = 1'b0; c_en = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic run_verified_load(input string tag, input logic exp_mm);
        int wb, rb, bad;
        bit ok;
        wb = wr_cnt; rb = rd_cnt;
        // Start cycle: cache request still passes through.
        @(posedge clock); #1;
        start = 1'b1; verify_en = 1'b1; c_en = 1'b1; c_wmode = 1'b0; c_addr = 6'd9;
        #1;
        checks++; if (RW0_en !== 1'b1 || RW0_addr !== 6'd9 || c_ready !== 1'b1) begin
            failures++; $display("FAIL %s_start_pass got en=%0b addr=%0d rdy=%0b exp en=1 addr=9 rdy=1", tag, RW0_en, RW0_addr, c_ready); end
        @(posedge clock); #1;
        start = 1'b0; verify_en = 1'b0; c_en = 1'b0;
        checks++; if (busy !== 1'b1 || c_ready !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL %s_load_state got busy=%0b rdy=%0b inr=%0b exp 1 0 1", tag, busy, c_ready, in_ready); end
        feed(0, SETS, 1'b0);
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL %s_done_timeout got=0 exp=1", tag); end
        checks++; if (wr_cnt - wb != SETS) begin failures++; $display("FAIL %s_writes got=%0d exp=%0d", tag, wr_cnt - wb, SETS); end
        bad = 0;
        for (int k = 0; k < SETS; k++) if (wr_log[wb + k] != k) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL %s_wr_order got=%0d exp=0", tag, bad); end
        checks++; if (rd_cnt - rb != SETS) begin failures++; $display("FAIL %s_reads got=%0d exp=%0d", tag, rd_cnt - rb, SETS); end
        bad = 0;
        for (int k = 0; k < SETS; k++) if (rd_log[rb + k] != k) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL %s_rd_order got=%0d exp=0", tag, bad); end
        checks++; if (done_rise - t_last != 67) begin failures++; $display("FAIL %s_latency got=%0d exp=67", tag, done_rise - t_last); end
        checks++; if (mismatch !== exp_mm) begin failures++; $display("FAIL %s_mismatch got=%0b exp=%0b", tag, mismatch, exp_mm); end
        checks++; if (busy !== 1'b0 || c_ready !== 1'b1) begin failures++; $display("FAIL %s_done_state got busy=%0b rdy=%0b exp 0 1", tag, busy, c_ready); end
    endtask

    task automatic test_verify_ok;
        run_verified_load("vok", 1'b0);
    endtask

    task automatic test_verify_corrupt;
        flip_en = 1'b1;
        run_verified_load("vbad", 1'b1);
        flip_en = 1'b0;
    endtask

    task automatic test_gaps;
        int wb, gb, cb, bad;
        bit ok;
        wb = wr_cnt; gb = gap_bad; cb = cr_bad;
        do_start(1'b0);
        // Cache keeps requesting writes during the load; they must be ignored.
        c_en = 1'b1; c_wmode = 1'b1; c_addr = 6'd40; c_wmask = '1;
        feed(0, SETS, 1'b1);
        c_en = 1'b0; c_wmode = 1'b0; c_wmask = '0;
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL gap_done_timeout got=0 exp=1"); end
        checks++; if (wr_cnt - wb != SETS) begin failures++; $display("FAIL gap_writes got=%0d exp=%0d", wr_cnt - wb, SETS); end
        bad = 0;
        for (int k = 0; k < SETS; k++) if (wr_log[wb + k] != k) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL gap_wr_order got=%0d exp=0", bad); end
        checks++; if (gap_bad - gb != 0) begin failures++; $display("FAIL gap_rw0_en got=%0d exp=0", gap_bad - gb); end
        checks++; if (cr_bad - cb != 0) begin failures++; $display("FAIL gap_c_ready got=%0d exp=0", cr_bad - cb); end
        checks++; if (done_rise - t_last != 1) begin failures++; $display("FAIL gap_latency got=%0d exp=1", done_rise - t_last); end
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL gap_mismatch got=%0b exp=0", mismatch); end
    endtask

    task automatic test_reset_midload;
        int wb;
        bit ok;
        do_start(1'b1);
        feed(0, 31, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || c_ready !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL mid_rst got busy=%0b rdy=%0b inr=%0b done=%0b exp 0 1 0 0", busy, c_ready, in_ready, done); end
        wb = wr_cnt;
        do_start(1'b0);
        feed(0, SETS, 1'b0);
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_done_timeout got=0 exp=1"); end
        checks++; if (wr_log[wb] != 0) begin failures++; $display("FAIL mid_first_addr got=%0d exp=0", wr_log[wb]); end
        checks++; if (wr_cnt - wb != SETS) begin failures++; $display("FAIL mid_writes got=%0d exp=%0d", wr_cnt - wb, SETS); end
        checks++; if (done_rise - t_last != 1) begin failures++; $display("FAIL mid_latency got=%0d exp=1", done_rise - t_last); end
    endtask

    task automatic test_back_to_back;
        int wb, bad;
        bit ok;
        wb = wr_cnt;
        do_start(1'b1);
        feed(0, 10, 1'b0);
        // Start with verify off mid-load: must not restart nor change verify mode.
        start = 1'b1; verify_en = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ignore got busy=%0b inr=%0b exp 1 1", busy, in_ready); end
        feed(10, SETS - 10, 1'b0);
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_done_timeout got=0 exp=1"); end
        bad = 0;
        for (int k = 0; k < SETS; k++) if (wr_log[wb + k] != k) bad++;
        checks++; if (bad != 0 || wr_cnt - wb != SETS) begin failures++; $display("FAIL b2b_wr_order got bad=%0d n=%0d exp 0 %0d", bad, wr_cnt - wb, SETS); end
        checks++; if (done_rise - t_last != 67) begin failures++; $display("FAIL b2b_latency got=%0d exp=67", done_rise - t_last); end
        // Restart from DONE, verify off.
        wb = wr_cnt;
        do_start(1'b0);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL reload_clear got done=%0b busy=%0b exp 0 1", done, busy); end
        feed(0, SETS, 1'b0);
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL reload_done_timeout got=0 exp=1"); end
        checks++; if (wr_cnt - wb != SETS || wr_log[wb] != 0) begin failures++; $display("FAIL reload_writes got n=%0d first=%0d exp %0d 0", wr_cnt - wb, wr_log[wb], SETS); end
        checks++; if (done_rise - t_last != 1) begin failures++; $display("FAIL reload_latency got=%0d exp=1", done_rise - t_last); end
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL reload_mismatch got=%0b exp=0", mismatch); end
    endtask

    initial begin
        test_reset();
        test_verify_ok();
        test_verify_corrupt();
        test_gaps();
        test_reset_midload();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tag_array_loader.md
TAG_ARRAY_LOADER -- requirements
Module: tag_array_loader

Interface
REQ-001 SHALL have parameter SETS, default 64, number of tag-array sets.
REQ-002 SHALL have parameter WAYS, default 4, number of ways per set.
REQ-003 SHALL have parameter TAG_BITS, default 22, per-way tag width (raw tag plus 2 coherency bits).
REQ-004 SHALL have parameter ADDR_BITS, default $clog2(SETS), set-index width.
REQ-005 SHALL have the following ports; one clock; reset is synchronous and active-high:
  clock  input  1  sole clock, rising edge
  reset  input  1  synchronous, active-high
  start  input  1  single-cycle pulse; begins a warmup load
  verify_en  input  1  sampled with start; enables readback check
  in_valid  input  1  warmup row available
  in_ready  output  1  loader accepts row
  in_data  input  WAYS*TAG_BITS  full row for current set, way w at bits [TAG_BITS*w +: TAG_BITS]
  c_en, c_wmode  input  1 each  cache-side SRAM request
  c_addr  input  ADDR_BITS  cache-side set index
  c_wdata  input  WAYS*TAG_BITS  cache-side write data
  c_wmask  input  WAYS  cache-side per-way write mask
  c_ready  output  1  cache owns the SRAM port
  c_rdata  output  WAYS*TAG_BITS  read data to cache
  RW0_en, RW0_wmode  output  1 each  to tag_array_ext
  RW0_addr  output  ADDR_BITS  to tag_array_ext
  RW0_wdata  output  WAYS*TAG_BITS  to tag_array_ext
  RW0_wmask  output  WAYS  to tag_array_ext
  RW0_rdata  input  WAYS*TAG_BITS  from tag_array_ext, valid one cycle after read
  busy  output  1  state not IDLE/DONE
  done  output  1  load complete, held until next start or reset
  mismatch  output  1  readback checksum failed, held with done

Function
REQ-006 SHALL implement states IDLE, LOAD, VERIFY, DRAIN, CMP, DONE.
REQ-007 In IDLE and DONE SHALL pass c_en/c_wmode/c_addr/c_wdata/c_wmask combinationally to RW0_*, c_ready=1, in_ready=0.
REQ-008 c_rdata SHALL equal RW0_rdata in every state.
REQ-009 In LOAD/VERIFY/DRAIN/CMP SHALL drive c_ready=0 and ignore cache requests.
REQ-010 start in IDLE or DONE SHALL: register verify_en, clear done/mismatch, zero set counter and both accumulators, enter LOAD next cycle; cache request in the start cycle still passes through.
REQ-011 start in any other state SHALL be ignored.
REQ-012 LOAD: in_ready=1; on in_valid&in_ready SHALL drive same-cycle RW0_en=1, RW0_wmode=1, RW0_addr=set counter, RW0_wdata=in_data, RW0_wmask=all ones; XOR in_data into write accumulator; increment counter.
REQ-013 LOAD with in_valid=0 SHALL drive RW0_en=0 and hold counter; no timeout.
REQ-014 Accepting the row for set SETS-1 SHALL move to VERIFY if verify_en was set, else DONE (mismatch=0), next cycle.
REQ-015 VERIFY: SHALL issue one read per cycle, RW0_en=1, RW0_wmode=0, RW0_wmask=0, addresses 0..SETS-1 in order, no stalls.
REQ-016 Read data for address k SHALL be XORed into read accumulator in the following cycle (VERIFY for k<SETS-1, DRAIN for k=SETS-1).
REQ-017 After the read of SETS-1, SHALL spend one cycle in DRAIN (RW0_en=0), one in CMP registering mismatch=(write acc != read acc), then DONE.
REQ-018 Latency: last row accepted at cycle T, verify on -> done=1 at T+SETS+3 (T+67 default); verify off -> T+1.
REQ-019 Set counter SHALL be ADDR_BITS wide and never wrap within one load; the transition at SETS-1 takes priority.
REQ-020 busy SHALL be 1 exactly in LOAD, VERIFY, DRAIN, CMP.

Reset
REQ-021 reset SHALL force IDLE from any state, including mid-load, next cycle.
REQ-022 Reset values: done=0, mismatch=0, busy=0, in_ready=0, c_ready=1, counter=0, accumulators=0, registered verify_en=0.
REQ-023 A load aborted by reset SHALL leave partially written SRAM contents as-is; the next start rewrites from set 0.

Verification
REQ-024 Reset with c_en=1, c_addr=5 -> RW0_en=1, RW0_addr=5 same cycle, c_ready=1, done=0, busy=0.
REQ-025 start, verify_en=1, 64 back-to-back rows, row i={4{22'(i)}}, behavioural SRAM -> writes addr 0..63, reads 0..63, done at T+67, mismatch=0.
REQ-026 As REQ-025 but SRAM model flips bit 3 of set 17 after write -> done at T+67, mismatch=1.
REQ-027 Random in_valid gaps (~50%) -> exactly 64 writes, addresses strictly increasing, RW0_en=0 on gap cycles, c_ready=0 throughout.
REQ-028 reset asserted after set 30 accepted -> IDLE next cycle, busy=0, c_ready=1; new start writes first row to addr 0.
REQ-029 start during LOAD ignored; start in DONE with verify_en=0 -> reload, done at T+1, mismatch=0.
